// File: rtl/scoot_world.sv
// Grid-world environment for one scootBot: owns the item grid and the agent position, drives the looks and samples moves once per step.
// Define SCOOT_WORLD_WALLS_EN for a bounded arena (clamped moves, off-grid looks read 0); the default is a toroidal wrap.
module scoot_world #(
  parameter int              WIDTH       = 10,
  parameter int              HEIGHT      = 10,
  parameter logic [HEIGHT-1:0] INIT_COL  = 10'b0010101001,
  parameter int              STEP_CYCLES = 8,
  parameter int              NUM_STEPS   = 100
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               mUp,
  input  logic                               mRight,
  input  logic                               mDown,
  input  logic                               mLeft,
  output logic                               lUp,
  output logic                               lRight,
  output logic                               lDown,
  output logic                               lLeft,
  output logic [$clog2(WIDTH)-1:0]           pos_x,
  output logic [$clog2(HEIGHT)-1:0]          pos_y,
  output logic [$clog2(WIDTH*HEIGHT+1)-1:0]  score,
  output logic                               picked,
  output logic                               busy,
  output logic                               done
);

  localparam int XW  = $clog2(WIDTH);
  localparam int YW  = $clog2(HEIGHT);
  localparam int WCW = $clog2(STEP_CYCLES + 1);
  localparam int SCW = $clog2(NUM_STEPS + 1);

`ifdef SCOOT_WORLD_WALLS_EN
  localparam bit WALLS = 1'b1;
`else
  localparam bit WALLS = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, INIT, SENSE, WAIT, MOVE, DONE} state_t;

  state_t             state;
  logic [HEIGHT-1:0]  grid [WIDTH];
  logic [WCW-1:0]     wait_cnt;
  logic [SCW-1:0]     step_cnt;

  logic            at_top, at_bottom, at_right, at_left;
  logic [XW-1:0]   x_right, x_left, next_x;
  logic [YW-1:0]   y_up, y_down, next_y;
  logic            look_up, look_right, look_down, look_left;
  logic            go_up, go_right, go_down, go_left;

  // Neighbour coordinates always wrap; in walled mode the edge flags mask them instead.
  assign at_top    = (pos_y == YW'(HEIGHT - 1));
  assign at_bottom = (pos_y == '0);
  assign at_right  = (pos_x == XW'(WIDTH - 1));
  assign at_left   = (pos_x == '0);

  assign y_up    = at_top    ? '0 : pos_y + 1'b1;
  assign y_down  = at_bottom ? YW'(HEIGHT - 1) : pos_y - 1'b1;
  assign x_right = at_right  ? '0 : pos_x + 1'b1;
  assign x_left  = at_left   ? XW'(WIDTH - 1) : pos_x - 1'b1;

  assign look_up    = !(WALLS && at_top)    && grid[pos_x][y_up];
  assign look_down  = !(WALLS && at_bottom) && grid[pos_x][y_down];
  assign look_right = !(WALLS && at_right)  && grid[x_right][pos_y];
  assign look_left  = !(WALLS && at_left)   && grid[x_left][pos_y];

  assign go_up    = mUp    && !mDown;
  assign go_down  = mDown  && !mUp;
  assign go_right = mRight && !mLeft;
  assign go_left  = mLeft  && !mRight;

  always_comb begin
    next_x = pos_x;
    next_y = pos_y;
    if (go_right && !(WALLS && at_right))
      next_x = x_right;
    else if (go_left && !(WALLS && at_left))
      next_x = x_left;
    if (go_up && !(WALLS && at_top))
      next_y = y_up;
    else if (go_down && !(WALLS && at_bottom))
      next_y = y_down;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pos_x    <= '0;
      pos_y    <= '0;
      score    <= '0;
      picked   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      lUp      <= 1'b0;
      lRight   <= 1'b0;
      lDown    <= 1'b0;
      lLeft    <= 1'b0;
      wait_cnt <= '0;
      step_cnt <= '0;
      for (int i = 0; i < WIDTH; i++) grid[i] <= '0;
    end else begin
      picked <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= INIT;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        INIT: begin
          for (int i = 0; i < WIDTH; i++) grid[i] <= INIT_COL;
          pos_x    <= XW'(WIDTH / 2);
          pos_y    <= YW'(HEIGHT / 2);
          score    <= '0;
          step_cnt <= '0;
          state    <= SENSE;
        end
        SENSE: begin
          // The current cell is never its own neighbour, so clearing it cannot disturb the looks.
          if (grid[pos_x][pos_y]) begin
            grid[pos_x][pos_y] <= 1'b0;
            if (score != '1) score <= score + 1'b1;
            picked <= 1'b1;
          end
          lUp      <= look_up;
          lRight   <= look_right;
          lDown    <= look_down;
          lLeft    <= look_left;
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == WCW'(STEP_CYCLES - 1))
            state <= MOVE;
          else
            wait_cnt <= wait_cnt + 1'b1;
        end
        MOVE: begin
          pos_x    <= next_x;
          pos_y    <= next_y;
          step_cnt <= step_cnt + 1'b1;
          if (step_cnt == SCW'(NUM_STEPS - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= SENSE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scoot_world.sv
// Self-checking bench for scoot_world: a behavioural grid model pushes expected step results into a scoreboard
// that is popped at the first WAIT cycle of every step; reset abort, start-while-busy and done timing are covered too.
module tb_scoot_world;

  localparam int W  = 10;
  localparam int H  = 10;
  localparam int SC = 8;
  localparam int NS = 100;

  logic       clk = 1'b0;
  logic       reset, start, mUp, mRight, mDown, mLeft;
  logic       lUp, lRight, lDown, lLeft;
  logic [3:0] pos_x, pos_y;
  logic [6:0] score;
  logic       picked, busy, done;

  typedef struct {
    int px;
    int py;
    int sc;
    int lk;
    int pk;
  } exp_t;

  exp_t           sbq[$];
  int             errCount   = 0;
  int             checkCount = 0;
  bit             mg [W][H];
  int             mx, my, msc;
  logic [H-1:0]   initCol    = 10'b0010101001;

  scoot_world dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mUp    (mUp),
    .mRight (mRight),
    .mDown  (mDown),
    .mLeft  (mLeft),
    .lUp    (lUp),
    .lRight (lRight),
    .lDown  (lDown),
    .lLeft  (lLeft),
    .pos_x  (pos_x),
    .pos_y  (pos_y),
    .score  (score),
    .picked (picked),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [3:0] mv);
    {mUp, mRight, mDown, mLeft} = mv;
  endtask

  function automatic logic [3:0] moveFor(input int ep, input int k);
    logic [3:0] r;
    r = 4'($urandom_range(0, 15));
    if (ep == 2) return 4'b0000;
    if (ep == 1) begin
      if (k < 2)  return 4'b1000;
      if (k < 10) return 4'b0010;
      if (k < 15) return 4'b0100;
      if (k < 17) return 4'b1111;
      if (k == 17) return 4'b1010;
      if (k == 18) return 4'b0101;
    end
    return r;
  endfunction

  task automatic modelInit();
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++)
        mg[x][y] = initCol[y];
    mx  = W / 2;
    my  = H / 2;
    msc = 0;
  endtask

  task automatic modelSense(output exp_t e);
    int up, rt, dn, lf;
    e.pk = 0;
    if (mg[mx][my]) begin
      mg[mx][my] = 1'b0;
      msc++;
      e.pk = 1;
    end
    up = mg[mx][(my + 1) % H];
    dn = mg[mx][(my + H - 1) % H];
    rt = mg[(mx + 1) % W][my];
    lf = mg[(mx + W - 1) % W][my];
`ifdef SCOOT_WORLD_WALLS_EN
    if (my == H - 1) up = 0;
    if (my == 0)     dn = 0;
    if (mx == W - 1) rt = 0;
    if (mx == 0)     lf = 0;
`endif
    e.px = mx;
    e.py = my;
    e.sc = msc;
    e.lk = up * 8 + rt * 4 + dn * 2 + lf;
  endtask

  task automatic modelMove(input logic [3:0] mv);
    int dx, dy, nx, ny;
    dx = int'(mv[2]) - int'(mv[0]);
    dy = int'(mv[3]) - int'(mv[1]);
    nx = mx + dx;
    ny = my + dy;
`ifdef SCOOT_WORLD_WALLS_EN
    if (nx >= 0 && nx < W) mx = nx;
    if (ny >= 0 && ny < H) my = ny;
`else
    mx = (nx + W) % W;
    my = (ny + H) % H;
`endif
  endtask

  task automatic runEpisode(input int ep, input int abortAt);
    exp_t       e;
    logic [3:0] mv;
    int         n;
    sbq.delete();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    n = 0;
    while (!busy && n < 5) begin
      tick(1);
      n++;
    end
    checkOutput("start_busy", busy, 1);
    modelInit();
    modelSense(e);
    sbq.push_back(e);
    tick(2);
    for (int k = 0; k < NS; k++) begin
      if (sbq.size() == 0) begin
        checkOutput("sb_empty", 0, 1);
        break;
      end
      e = sbq.pop_front();
      checkOutput("pos_x",  pos_x, e.px);
      checkOutput("pos_y",  pos_y, e.py);
      checkOutput("score",  score, e.sc);
      checkOutput("looks",  {lUp, lRight, lDown, lLeft}, e.lk);
      checkOutput("picked", picked, e.pk);
      checkOutput("busy",   busy, 1);
      checkOutput("done",   done, 0);
      if (ep == 1 && k == 0) begin
        checkOutput("first_score", score, 1);
        checkOutput("first_looks", {lUp, lRight, lDown, lLeft}, 4'b0101);
        checkOutput("first_picked", picked, 1);
      end
      if (k == abortAt) begin
        reset = 1'b1;
        #1;
        checkOutput("abort_outputs",
                    {busy, done, picked, lUp, lRight, lDown, lLeft, pos_x, pos_y, score}, 0);
        tick(2);
        reset = 1'b0;
        tick(3);
        checkOutput("abort_idle", {busy, done}, 0);
        sbq.delete();
        return;
      end
      mv = moveFor(ep, k);
      applyStimulus(mv);
      tick(SC - 1);
      checkOutput("looks_held", {lUp, lRight, lDown, lLeft}, e.lk);
      checkOutput("picked_low", picked, 0);
      tick(1);
      checkOutput("done_early", done, 0);
      if (ep == 1 && k == 20) start = 1'b1;
      modelMove(mv);
      tick(1);
      start = 1'b0;
      applyStimulus(4'b0000);
      if (k < NS - 1) begin
        modelSense(e);
        sbq.push_back(e);
        tick(1);
      end
    end
    checkOutput("done_set",    done, 1);
    checkOutput("done_busy",   busy, 0);
    checkOutput("final_x",     pos_x, mx);
    checkOutput("final_y",     pos_y, my);
    checkOutput("final_score", score, msc);
    if (ep == 2) checkOutput("idle_score", score, 1);
    tick(3);
    checkOutput("done_hold", {done, busy}, 2'b10);
    checkOutput("done_score_hold", score, msc);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    applyStimulus(4'b0000);
    tick(2);
    checkOutput("reset_outputs",
                {busy, done, picked, lUp, lRight, lDown, lLeft, pos_x, pos_y, score}, 0);
    reset = 1'b0;
    tick(2);
    checkOutput("idle_after_reset", {busy, done}, 0);
    runEpisode(1, -1);
    runEpisode(2, -1);
    runEpisode(3, 4);
    runEpisode(4, -1);
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
